// File: rtl/lms_pkg.sv
// +--------------------------------------------------------------------+
// | lms_pkg : shared types and helpers for the LMS update sequencer    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package lms_pkg;

  localparam int LMS_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_WAIT_ERR = 3'd2,
    ST_UPDATE   = 3'd3,
    ST_CLEAR    = 3'd4
  } lms_sched_state_t;

  // Unsigned result so the most-negative input maps to 2^(W-1) without overflow.
  function automatic logic [LMS_DATA_W-1:0] abs_mag(input logic signed [LMS_DATA_W-1:0] v);
    logic [LMS_DATA_W-1:0] u;
    u = v;
    return u[LMS_DATA_W-1] ? ((~u) + LMS_DATA_W'(1)) : u;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lms_conv_detect.sv
// +--------------------------------------------------------------------+
// | lms_conv_detect : in-band run counter with sticky converged flag   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module lms_conv_detect
  import lms_pkg::*;
#(
  parameter int DATA_W      = LMS_DATA_W,
  parameter int CONV_THRESH = 2,
  parameter int CONV_COUNT  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] e,
  output logic                     converged
);

  localparam int                RUN_W   = $clog2(CONV_COUNT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(CONV_COUNT);
  localparam logic [DATA_W-1:0] THRESH  = DATA_W'(CONV_THRESH);

  logic [RUN_W-1:0] run_q, run_d;
  logic             conv_q, conv_d;
  logic             inband;

  assign inband = (abs_mag(e) <= THRESH);

  always_comb begin
    run_d  = run_q;
    conv_d = conv_q;
    if (clr) begin
      run_d  = '0;
      conv_d = 1'b0;
    end else if (sample) begin
      if (!inband)
        run_d = '0;
      else if (run_q != RUN_MAX)
        run_d = run_q + RUN_W'(1);
      conv_d = conv_q | (run_d == RUN_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= '0;
      conv_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      conv_q <= conv_d;
    end
  end

  assign converged = conv_q;

endmodule

`default_nettype wire

// File: rtl/lms_update_sched.sv
// +--------------------------------------------------------------------+
// | lms_update_sched : sample/error/update sequencer for LMS datapath  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module lms_update_sched
  import lms_pkg::*;
#(
  parameter int DATA_W      = LMS_DATA_W,
  parameter int CONV_THRESH = 2,
  parameter int CONV_COUNT  = 16,
  parameter int ERR_TIMEOUT = 8,
  parameter int ITER_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     freeze,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_x,
  input  logic signed [DATA_W-1:0] s_y,
  output logic signed [DATA_W-1:0] x_last,
  output logic signed [DATA_W-1:0] y_last,
  input  logic                     e_valid,
  input  logic signed [DATA_W-1:0] e_in,
  output logic signed [DATA_W-1:0] e_current,
  output logic                     upd_en,
  output logic                     coeff_clr,
  input  logic                     clear,
  output logic                     busy,
  output logic                     converged,
  output logic [ITER_W-1:0]        iter_cnt,
  output logic                     timeout_err
);

  localparam logic [7:0] TMO_LAST = 8'(ERR_TIMEOUT - 1);

  lms_sched_state_t         state_q, state_d;
  logic signed [DATA_W-1:0] x_q, x_d, y_q, y_d, e_q, e_d;
  logic [7:0]               tmo_q, tmo_d;
  logic [ITER_W-1:0]        iter_q, iter_d;
  logic                     tmo_err_q, tmo_err_d;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    e_d       = e_q;
    tmo_d     = tmo_q;
    iter_d    = iter_q;
    tmo_err_d = tmo_err_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
        end else if (s_valid && enable) begin
          x_d     = s_x;
          y_d     = s_y;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_ERR;
      end
      ST_WAIT_ERR: begin
        // A result arriving on the final allowed cycle still wins over the abort.
        if (e_valid) begin
          e_d     = e_in;
          state_d = ST_UPDATE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_UPDATE: begin
        if (!freeze && (iter_q != '1))
          iter_d = iter_q + ITER_W'(1);
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        iter_d    = '0;
        tmo_err_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      e_q       <= '0;
      tmo_q     <= '0;
      iter_q    <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      e_q       <= e_d;
      tmo_q     <= tmo_d;
      iter_q    <= iter_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  lms_conv_detect #(
    .DATA_W      (DATA_W),
    .CONV_THRESH (CONV_THRESH),
    .CONV_COUNT  (CONV_COUNT)
  ) u_conv (
    .clk       (clk),
    .rst       (rst),
    .sample    (state_q == ST_UPDATE),
    .clr       (state_q == ST_CLEAR),
    .e         (e_q),
    .converged (converged)
  );

  assign s_ready     = (state_q == ST_IDLE) & enable & ~clear;
  assign upd_en      = (state_q == ST_UPDATE) & ~freeze;
  assign coeff_clr   = (state_q == ST_CLEAR);
  assign busy        = (state_q != ST_IDLE);
  assign x_last      = x_q;
  assign y_last      = y_q;
  assign e_current   = e_q;
  assign iter_cnt    = iter_q;
  assign timeout_err = tmo_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lms_update_sched.sv
// +--------------------------------------------------------------------+
// | tb_lms_update_sched : scoreboard bench for lms_update_sched        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_lms_update_sched;

  logic clk = 1'b0;
  logic rst, enable, freeze, s_valid, e_valid, clear;
  logic signed [7:0] s_x, s_y, e_in;
  logic signed [7:0] x_last, y_last, e_current;
  logic s_ready, upd_en, coeff_clr, busy, converged, timeout_err;
  logic [15:0] iter_cnt;

  always #5 clk = ~clk;

  lms_update_sched dut (
    .clk(clk), .rst(rst), .enable(enable), .freeze(freeze),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .x_last(x_last), .y_last(y_last), .e_valid(e_valid), .e_in(e_in),
    .e_current(e_current), .upd_en(upd_en), .coeff_clr(coeff_clr),
    .clear(clear), .busy(busy), .converged(converged),
    .iter_cnt(iter_cnt), .timeout_err(timeout_err)
  );

  typedef struct {
    logic signed [7:0] x, y, e;
    int                upd, clr, cyc;
    logic [15:0]       iter;
    logic              conv, tmo;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  int                m_iter = 0, m_run = 0;
  logic              m_conv = 1'b0, m_tmo = 1'b0;
  logic signed [7:0] m_x = '0, m_y = '0, m_e = '0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int upd, input int clr, input int cyc);
    sb.push_back('{x: m_x, y: m_y, e: m_e, upd: upd, clr: clr, cyc: cyc,
                   iter: 16'(m_iter), conv: m_conv, tmo: m_tmo});
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_wait", 32'(busy), 0);
  endtask

  task automatic accept(input logic signed [7:0] x, input logic signed [7:0] y);
    logic r = 1'b0;
    wait_idle();
    @(posedge clk); #1;
    s_x = x; s_y = y; s_valid = 1'b1;
    for (int k = 0; k < 10 && !r; k++) begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
    end
    #1 s_valid = 1'b0;
    if (!r) check("accept_wait", 32'(r), 1);
  endtask

  task automatic sample(input logic signed [7:0] x, input logic signed [7:0] y,
                        input logic signed [7:0] e, input int d, input bit drop_en);
    int ev = int'(e);
    m_x = x; m_y = y; m_e = e;
    if (!freeze) m_iter++;
    if (ev >= -2 && ev <= 2) m_run = (m_run < 16) ? m_run + 1 : 16;
    else m_run = 0;
    if (m_run >= 16) m_conv = 1'b1;
    push_exp(freeze ? 0 : 1, 0, d + 2);
    accept(x, y);
    if (drop_en) enable = 1'b0;
    repeat (d) @(posedge clk);
    #1 e_valid = 1'b1; e_in = e;
    @(posedge clk); #1 e_valid = 1'b0;
  endtask

  task automatic timeout_op(input logic signed [7:0] x, input logic signed [7:0] y);
    m_x = x; m_y = y; m_tmo = 1'b1;
    push_exp(0, 0, 9);
    accept(x, y);
    wait_idle();
  endtask

  // Each operation ends when busy falls; the oldest expectation is then compared.
  initial begin
    bit   prev = 1'b0;
    int   cyc = 0, nu = 0, nc = 0;
    bit   both = 1'b0;
    exp_t ex;
    forever begin
      @(negedge clk);
      if (busy) begin
        cyc++;
        nu += int'(upd_en);
        nc += int'(coeff_clr);
        both |= (upd_en & coeff_clr);
      end
      if (prev && !busy) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 1);
        end else begin
          ex = sb.pop_front();
          check("op_x_last",    32'(x_last),      32'(ex.x));
          check("op_y_last",    32'(y_last),      32'(ex.y));
          check("op_e_current", 32'(e_current),   32'(ex.e));
          check("op_upd_pulses", nu,              ex.upd);
          check("op_clr_pulses", nc,              ex.clr);
          check("op_iter_cnt",  32'(iter_cnt),    32'(ex.iter));
          check("op_converged", 32'(converged),   32'(ex.conv));
          check("op_timeout",   32'(timeout_err), 32'(ex.tmo));
          check("op_upd_clr_overlap", 32'(both),  0);
          if (ex.cyc >= 0) check("op_busy_cycles", cyc, ex.cyc);
        end
        cyc = 0; nu = 0; nc = 0; both = 1'b0;
      end
      prev = busy;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_ready"}, 32'(s_ready), 0);
    check({tag, "_upd"},   32'(upd_en), 0);
    check({tag, "_clr"},   32'(coeff_clr), 0);
    check({tag, "_x"},     32'(x_last), 0);
    check({tag, "_y"},     32'(y_last), 0);
    check({tag, "_e"},     32'(e_current), 0);
    check({tag, "_iter"},  32'(iter_cnt), 0);
    check({tag, "_conv"},  32'(converged), 0);
    check({tag, "_tmo"},   32'(timeout_err), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; freeze = 1'b0; s_valid = 1'b0; e_valid = 1'b0;
    clear = 1'b0; s_x = '0; s_y = '0; e_in = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0; enable = 1'b1;

    // single sample, error two cycles after CAPTURE
    sample(8'sd5, -8'sd3, 8'sd4, 2, 1'b0);
    wait_idle();
    check("single_x", 32'(x_last), 5);
    check("single_y", 32'(y_last), -3);
    check("single_e", 32'(e_current), 4);
    check("single_iter", 32'(iter_cnt), 1);

    // stray error pulse while idle must be ignored
    @(posedge clk); #1 e_valid = 1'b1; e_in = 8'sd99;
    @(posedge clk); #1 e_valid = 1'b0;
    @(negedge clk);
    check("stray_e_ignored", 32'(e_current), 4);
    check("stray_e_busy", 32'(busy), 0);

    // 15 in-band then an out-of-band sample: no convergence
    for (int i = 0; i < 15; i++)
      sample(8'(i), 8'(-i), (i % 2) ? -8'sd2 : 8'sd2, 1, 1'b0);
    sample(8'sd1, 8'sd1, 8'sd3, 1, 1'b0);
    // most-negative error on the last permitted WAIT_ERR cycle
    sample(8'sd0, 8'sd0, -8'sd128, 8, 1'b0);
    wait_idle();
    check("broken_run_conv", 32'(converged), 0);

    for (int i = 0; i < 16; i++) begin
      sample(8'(i + 40), 8'(i), 8'((i % 5) - 2), 1, 1'b0);
      if (i == 14) begin
        wait_idle();
        check("conv_after_15", 32'(converged), 0);
      end
    end
    wait_idle();
    check("conv_after_16", 32'(converged), 1);
    check("iter_after_conv", 32'(iter_cnt), 34);

    timeout_op(8'sd11, 8'sd12);
    check("timeout_flag", 32'(timeout_err), 1);
    check("timeout_iter", 32'(iter_cnt), 34);

    // enable dropped mid-op: sample still completes, then no accepts
    sample(8'sd20, 8'sd21, 8'sd1, 1, 1'b1);
    wait_idle();
    check("en_drop_iter", 32'(iter_cnt), 35);
    check("en_drop_ready", 32'(s_ready), 0);
    enable = 1'b1;

    freeze = 1'b1;
    for (int i = 0; i < 3; i++) sample(8'(60 + i), 8'(-i), 8'sd7, 1, 1'b0);
    wait_idle();
    check("freeze_iter", 32'(iter_cnt), 35);
    check("freeze_x", 32'(x_last), 62);
    freeze = 1'b0;

    // clear and s_valid together: clear wins
    m_iter = 0; m_run = 0; m_conv = 1'b0; m_tmo = 1'b0;
    push_exp(0, 1, 1);
    wait_idle();
    @(posedge clk); #1 clear = 1'b1; s_valid = 1'b1; s_x = 8'sd77;
    @(negedge clk);
    check("clear_ready_low", 32'(s_ready), 0);
    @(posedge clk); #1 clear = 1'b0; s_valid = 1'b0;
    wait_idle();
    check("clear_x_kept", 32'(x_last), 62);
    check("clear_iter", 32'(iter_cnt), 0);
    check("clear_conv", 32'(converged), 0);
    check("clear_tmo", 32'(timeout_err), 0);

    sample(8'sd1, 8'sd2, 8'sd0, 1, 1'b0);
    wait_idle();
    check("post_clear_iter", 32'(iter_cnt), 1);

    // reset in the middle of WAIT_ERR
    m_x = '0; m_y = '0; m_e = '0; m_iter = 0; m_run = 0; m_conv = 1'b0; m_tmo = 1'b0;
    push_exp(0, 0, -1);
    accept(8'sd9, 8'sd9);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; enable = 1'b0;
    #1 check_all_zero("midop_reset");
    @(posedge clk); #1 check_all_zero("midop_reset_hold");
    rst = 1'b0;

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
